// File: rtl/light_pkg.sv
// Shared light-state codes and small helpers for the light sequencer and decoder.
package light_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_MAINT  = 2'b11
  } lightState_t;

  localparam int MS_PER_S = 1000;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// Request/indication bundle between the light sequencer and its environment.
interface light_sequencer_if;
  logic       inPed;
  logic       inMaint;
  logic [1:0] outSel;
  logic       outPedPend;

  modport master (output inPed, output inMaint, input outSel, input outPedPend);
  modport slave  (input inPed, input inMaint, output outSel, output outPedPend);
endinterface

// File: rtl/light_sequencer_tick_gen.sv
// Millisecond prescaler: one-cycle tick every C_DIV clocks, restartable via clear.
module tick_gen #(
  parameter int C_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(C_DIV - 1);

  logic [CW-1:0] countReg;

  assign tick = (countReg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countReg <= '0;
    end else if (clear || tick) begin
      countReg <= '0;
    end else begin
      countReg <= countReg + CW'(1);
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Traffic light phase sequencer with pedestrian shortening of green and a maintenance override.
module light_sequencer
  import light_pkg::*;
#(
  parameter int C_CLK_FRQ      = 100000000,
  parameter int C_RED_MS       = 5000,
  parameter int C_GREEN_MS     = 5000,
  parameter int C_YELLOW_MS    = 1000,
  parameter int C_MIN_GREEN_MS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  light_sequencer_if.slave  bus
);

  localparam int MAX_MS = maxOf3(C_RED_MS, C_GREEN_MS, C_YELLOW_MS);
  localparam int TW     = $clog2(MAX_MS + 1);

  typedef logic [TW-1:0] msCount_t;

  localparam msCount_t RED_LEN    = msCount_t'(C_RED_MS);
  localparam msCount_t GREEN_LEN  = msCount_t'(C_GREEN_MS);
  localparam msCount_t YELLOW_LEN = msCount_t'(C_YELLOW_MS);
  localparam msCount_t MIN_LEN    = msCount_t'(C_MIN_GREEN_MS);

  generate
    if (C_RED_MS < 1 || C_GREEN_MS < 1 || C_YELLOW_MS < 1 || C_MIN_GREEN_MS < 1) begin : gBadDuration
      $error("light_sequencer: every duration must be at least 1 ms");
    end
    if (C_MIN_GREEN_MS > C_GREEN_MS) begin : gBadMinGreen
      $error("light_sequencer: minimum green exceeds nominal green");
    end
    if ((C_CLK_FRQ % MS_PER_S) != 0 || C_CLK_FRQ < 2 * MS_PER_S) begin : gBadClock
      $error("light_sequencer: clock frequency must be a multiple of 1000 and at least 2000");
    end
  endgenerate

  lightState_t stateReg, stateNext;
  logic        pendReg, pendNext;
  msCount_t    timerReg;
  msCount_t    msReached;
  logic        tick;
  logic        phaseClear;

  tick_gen #(
    .C_DIV(C_CLK_FRQ / MS_PER_S)
  ) uTickGen (
    .clk  (clk),
    .rst  (rst),
    .clear(phaseClear),
    .tick (tick)
  );

  // Elapsed ms in this phase once the current tick is counted.
  assign msReached  = timerReg + msCount_t'(1);
  // Holding timers at zero in MAINT keeps them from wrapping while parked there.
  assign phaseClear = (stateNext != stateReg) || (stateReg == ST_MAINT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= ST_RED;
      pendReg  <= 1'b0;
      timerReg <= '0;
    end else begin
      stateReg <= stateNext;
      pendReg  <= pendNext;
      if (phaseClear) begin
        timerReg <= '0;
      end else if (tick) begin
        timerReg <= msReached;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    pendNext  = pendReg;

    case (stateReg)
      ST_RED: begin
        if (tick && msReached == RED_LEN) stateNext = ST_GREEN;
      end
      ST_GREEN: begin
        if (tick && (msReached == GREEN_LEN || (msReached >= MIN_LEN && pendReg)))
          stateNext = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (tick && msReached == YELLOW_LEN) stateNext = ST_RED;
      end
      ST_MAINT: begin
        if (!bus.inMaint) stateNext = ST_RED;
      end
      default: stateNext = ST_RED;
    endcase

    if (bus.inMaint) stateNext = ST_MAINT;

    if (stateReg != ST_MAINT && bus.inPed) pendNext = 1'b1;
    // A request is served by entering red; a same-edge set loses to that clear.
    if (stateNext == ST_MAINT || (stateNext == ST_RED && stateReg != ST_RED))
      pendNext = 1'b0;
  end

  assign bus.outSel     = stateReg;
  assign bus.outPedPend = pendReg;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench: directed phase-timing scenarios plus randomized requests against a cycle-count model.
module tb_light_sequencer;

  localparam int FRQ      = 10000;
  localparam int RED_MS   = 5;
  localparam int GREEN_MS = 5;
  localparam int YEL_MS   = 2;
  localparam int MIN_MS   = 2;
  localparam int DIV      = FRQ / 1000;

  localparam int P_RED   = 0;
  localparam int P_GREEN = 1;
  localparam int P_YEL   = 2;
  localparam int P_MAINT = 3;

  logic clk = 1'b0;
  logic rst;

  light_sequencer_if bus();

  light_sequencer #(
    .C_CLK_FRQ     (FRQ),
    .C_RED_MS      (RED_MS),
    .C_GREEN_MS    (GREEN_MS),
    .C_YELLOW_MS   (YEL_MS),
    .C_MIN_GREEN_MS(MIN_MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Model: phase plus cycles spent in it; ms ticks derived by division.
  int mPhase = P_RED;
  int mCyc   = 0;
  bit mPend  = 1'b0;

  task automatic modelStep();
    int  msAfter;
    bit  tickNow;
    int  nextPhase;
    bit  nextPend;
    if (rst) begin
      mPhase = P_RED;
      mCyc   = 0;
      mPend  = 1'b0;
    end else begin
      msAfter   = (mCyc + 1) / DIV;
      tickNow   = ((mCyc + 1) % DIV) == 0;
      nextPhase = mPhase;
      if (mPhase == P_RED && tickNow && msAfter == RED_MS) nextPhase = P_GREEN;
      if (mPhase == P_GREEN && tickNow && (msAfter == GREEN_MS || (msAfter >= MIN_MS && mPend)))
        nextPhase = P_YEL;
      if (mPhase == P_YEL && tickNow && msAfter == YEL_MS) nextPhase = P_RED;
      if (mPhase == P_MAINT && !bus.inMaint) nextPhase = P_RED;
      if (bus.inMaint) nextPhase = P_MAINT;
      nextPend = mPend;
      if (mPhase != P_MAINT && bus.inPed) nextPend = 1'b1;
      if (nextPhase == P_MAINT || (nextPhase == P_RED && mPhase != P_RED)) nextPend = 1'b0;
      mCyc   = (nextPhase != mPhase || mPhase == P_MAINT) ? 0 : mCyc + 1;
      mPhase = nextPhase;
      mPend  = nextPend;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.inPed = 1'b0;
    bus.inMaint = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checkCount++;
    if (bus.outSel !== 2'd0) $display("FAIL reset_sel: outSel=%0d expected=0", bus.outSel);
    else passCount++;
    checkCount++;
    if (bus.outPedPend !== 1'b0) $display("FAIL reset_pend: outPedPend=%0b expected=0", bus.outPedPend);
    else passCount++;
    bus.inPed = 1'b1;
    cycles(2);
    checkCount++;
    if (bus.outPedPend !== 1'b0 || bus.outSel !== 2'd0)
      $display("FAIL reset_hold: outSel=%0d outPedPend=%0b expected 0/0", bus.outSel, bus.outPedPend);
    else passCount++;
    bus.inPed = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    int p;
    logic [1:0] expSel;
    doReset();
    for (int k = 1; k <= 240; k++) begin
      cycle();
      p = k % 120;
      expSel = (p < 50) ? 2'd0 : (p < 100) ? 2'd1 : 2'd2;
      checkCount++;
      if (bus.outSel !== expSel)
        $display("FAIL free_run_sel cycle %0d: outSel=%0d expected=%0d", k, bus.outSel, expSel);
      else passCount++;
    end
    checkCount++;
    if (bus.outPedPend !== 1'b0) $display("FAIL free_run_pend: outPedPend=%0b expected=0", bus.outPedPend);
    else passCount++;
    $display("test_free_run done");
  endtask

  task automatic test_ped_early();
    doReset();
    cycles(55);
    bus.inPed = 1'b1;
    cycle();
    bus.inPed = 1'b0;
    checkCount++;
    if (bus.outPedPend !== 1'b1) $display("FAIL ped_early_set: outPedPend=%0b expected=1", bus.outPedPend);
    else passCount++;
    cycles(13);
    checkCount++;
    if (bus.outSel !== 2'd1) $display("FAIL ped_early_green19: outSel=%0d expected=1", bus.outSel);
    else passCount++;
    cycle();
    checkCount++;
    if (bus.outSel !== 2'd2) $display("FAIL ped_early_yellow20: outSel=%0d expected=2", bus.outSel);
    else passCount++;
    cycles(19);
    checkCount++;
    if (bus.outSel !== 2'd2 || bus.outPedPend !== 1'b1)
      $display("FAIL ped_early_yellow_end: outSel=%0d outPedPend=%0b expected 2/1", bus.outSel, bus.outPedPend);
    else passCount++;
    cycle();
    checkCount++;
    if (bus.outSel !== 2'd0 || bus.outPedPend !== 1'b0)
      $display("FAIL ped_early_red_entry: outSel=%0d outPedPend=%0b expected 0/0", bus.outSel, bus.outPedPend);
    else passCount++;
    $display("test_ped_early done");
  endtask

  task automatic test_ped_late();
    doReset();
    cycles(85);
    bus.inPed = 1'b1;
    cycle();
    bus.inPed = 1'b0;
    checkCount++;
    if (bus.outPedPend !== 1'b1) $display("FAIL ped_late_set: outPedPend=%0b expected=1", bus.outPedPend);
    else passCount++;
    cycles(3);
    checkCount++;
    if (bus.outSel !== 2'd1) $display("FAIL ped_late_green39: outSel=%0d expected=1", bus.outSel);
    else passCount++;
    cycle();
    checkCount++;
    if (bus.outSel !== 2'd2) $display("FAIL ped_late_yellow40: outSel=%0d expected=2", bus.outSel);
    else passCount++;
    $display("test_ped_late done");
  endtask

  task automatic test_maint();
    doReset();
    cycles(119);
    checkCount++;
    if (bus.outSel !== 2'd2) $display("FAIL maint_pre_yellow: outSel=%0d expected=2", bus.outSel);
    else passCount++;
    bus.inMaint = 1'b1;
    bus.inPed = 1'b1;
    cycle();
    checkCount++;
    if (bus.outSel !== 2'd3 || bus.outPedPend !== 1'b0)
      $display("FAIL maint_enter: outSel=%0d outPedPend=%0b expected 3/0", bus.outSel, bus.outPedPend);
    else passCount++;
    cycles(3);
    checkCount++;
    if (bus.outSel !== 2'd3 || bus.outPedPend !== 1'b0)
      $display("FAIL maint_ped_ignored: outSel=%0d outPedPend=%0b expected 3/0", bus.outSel, bus.outPedPend);
    else passCount++;
    bus.inMaint = 1'b0;
    bus.inPed = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      cycle();
      checkCount++;
      if (bus.outSel !== 2'd0) $display("FAIL maint_exit_red cycle %0d: outSel=%0d expected=0", k, bus.outSel);
      else passCount++;
    end
    cycle();
    checkCount++;
    if (bus.outSel !== 2'd1) $display("FAIL maint_exit_green: outSel=%0d expected=1", bus.outSel);
    else passCount++;
    $display("test_maint done");
  endtask

  task automatic test_reset_mid();
    doReset();
    cycles(52);
    bus.inPed = 1'b1;
    cycle();
    bus.inPed = 1'b0;
    cycles(7);
    checkCount++;
    if (bus.outSel !== 2'd1 || bus.outPedPend !== 1'b1)
      $display("FAIL reset_mid_pre: outSel=%0d outPedPend=%0b expected 1/1", bus.outSel, bus.outPedPend);
    else passCount++;
    #1;
    rst = 1'b1;
    bus.inPed = 1'b1;
    #1;
    checkCount++;
    if (bus.outSel !== 2'd0 || bus.outPedPend !== 1'b0)
      $display("FAIL reset_mid_async: outSel=%0d outPedPend=%0b expected 0/0", bus.outSel, bus.outPedPend);
    else passCount++;
    cycle();
    rst = 1'b0;
    bus.inPed = 1'b0;
    cycles(49);
    checkCount++;
    if (bus.outSel !== 2'd0) $display("FAIL reset_mid_red49: outSel=%0d expected=0", bus.outSel);
    else passCount++;
    cycle();
    checkCount++;
    if (bus.outSel !== 2'd1) $display("FAIL reset_mid_green50: outSel=%0d expected=1", bus.outSel);
    else passCount++;
    $display("test_reset_mid done");
  endtask

  task automatic test_ped_hold();
    doReset();
    bus.inPed = 1'b1;
    cycle();
    checkCount++;
    if (bus.outPedPend !== 1'b1) $display("FAIL ped_hold_set: outPedPend=%0b expected=1", bus.outPedPend);
    else passCount++;
    cycles(88);
    checkCount++;
    if (bus.outSel !== 2'd2 || bus.outPedPend !== 1'b1)
      $display("FAIL ped_hold_pre_red: outSel=%0d outPedPend=%0b expected 2/1", bus.outSel, bus.outPedPend);
    else passCount++;
    cycle();
    checkCount++;
    if (bus.outSel !== 2'd0 || bus.outPedPend !== 1'b0)
      $display("FAIL ped_hold_red_entry: outSel=%0d outPedPend=%0b expected 0/0", bus.outSel, bus.outPedPend);
    else passCount++;
    cycle();
    checkCount++;
    if (bus.outPedPend !== 1'b1) $display("FAIL ped_hold_reset: outPedPend=%0b expected=1", bus.outPedPend);
    else passCount++;
    bus.inPed = 1'b0;
    $display("test_ped_hold done");
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    doReset();
    for (int k = 0; k < 4000; k++) begin
      bus.inPed = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 999) < 12) bus.inMaint = ~bus.inMaint;
      cycle();
      checkCount++;
      if (bus.outSel !== 2'(mPhase)) begin
        $display("FAIL random_sel cycle %0d: outSel=%0d expected=%0d", k, bus.outSel, mPhase);
        bad++;
      end else passCount++;
      checkCount++;
      if (bus.outPedPend !== mPend) begin
        $display("FAIL random_pend cycle %0d: outPedPend=%0b expected=%0b", k, bus.outPedPend, mPend);
        bad++;
      end else passCount++;
    end
    bus.inPed = 1'b0;
    bus.inMaint = 1'b0;
    $display("test_random done, %0d discrepancies", bad);
  endtask

  initial begin
    rst = 1'b1;
    bus.inPed = 1'b0;
    bus.inMaint = 1'b0;
    test_reset();
    test_free_run();
    test_ped_early();
    test_ped_late();
    test_maint();
    test_reset_mid();
    test_ped_hold();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 C_CLK_FRQ, 100000000, clock frequency in cycles per second.
REQ-002 C_RED_MS, 5000, red phase duration in ms.
REQ-003 C_GREEN_MS, 5000, nominal green phase duration in ms.
REQ-004 C_YELLOW_MS, 1000, yellow phase duration in ms.
REQ-005 C_MIN_GREEN_MS, 1000, minimum green before a pedestrian request may end it, in ms.
REQ-006 clk  input  1  master clock; single clock domain.
REQ-007 rst  input  1  asynchronous reset, active-high.
REQ-008 inPed  input  1  pedestrian request, level, already debounced and synchronous to clk.
REQ-009 inMaint  input  1  maintenance mode request, level, already debounced and synchronous to clk.
REQ-010 outSel  output  2  light selection toward the light decoder: 00 red, 01 green, 10 yellow, 11 white (maintenance).
REQ-011 outPedPend  output  1  pedestrian request latched and not yet served.

Function
REQ-012 A prescaler SHALL emit a one-cycle ms tick every C_CLK_FRQ/1000 clk cycles; it SHALL restart from zero on every state transition.
REQ-013 A phase timer SHALL count ms ticks in the current state and SHALL clear on every state transition.
REQ-014 States SHALL be RED, GREEN, YELLOW, MAINT; outSel SHALL be a register equal to the state code, changing on the same edge as the state.
REQ-015 RED -> GREEN on the tick at which the phase timer reaches C_RED_MS.
REQ-016 GREEN -> YELLOW on the tick at which the timer reaches C_GREEN_MS, or on the first tick with timer >= C_MIN_GREEN_MS while outPedPend = 1.
REQ-017 YELLOW -> RED on the tick at which the timer reaches C_YELLOW_MS.
REQ-018 inPed = 1 in RED, GREEN, or YELLOW SHALL set outPedPend on the next edge.
REQ-019 outPedPend SHALL clear on the edge entering RED; set and clear on the same edge resolves to clear.
REQ-020 inMaint = 1 SHALL force MAINT on the next edge from any state, overriding any concurrent timed transition; it SHALL clear timers and outPedPend; inPed SHALL be ignored in MAINT.
REQ-021 In MAINT with inMaint = 0, the next edge SHALL enter RED with a full C_RED_MS phase.
REQ-022 Phase transition latency SHALL be exactly one clk after the qualifying tick; phase length in cycles = duration_ms * C_CLK_FRQ/1000 (+/- 0).
REQ-023 Timer widths SHALL be derived from the largest duration parameter; no wrap-around SHALL occur for valid parameters.
REQ-024 All duration parameters SHALL be >= 1, C_MIN_GREEN_MS <= C_GREEN_MS, and C_CLK_FRQ a multiple of 1000 >= 2000; violations SHALL be flagged at elaboration.

Reset
REQ-025 While rst = 1: state RED, outSel = 00, outPedPend = 0, prescaler and phase timer = 0, asynchronously.
REQ-026 After rst deasserts, a full C_RED_MS red phase SHALL elapse before GREEN; reset asserted mid-phase SHALL abort that phase with no partial output.

Structure
REQ-027 The state codes (RED 00, GREEN 01, YELLOW 10, MAINT 11) SHALL be constants in the shared package light_pkg, reused by the light decoder.
REQ-028 The ms prescaler SHALL be a sub-module tick_gen (ports clk, rst, clear, tick); the FSM and timers remain in light_sequencer.

Verification (C_CLK_FRQ = 10000, C_RED_MS = 5, C_GREEN_MS = 5, C_YELLOW_MS = 2, C_MIN_GREEN_MS = 2)
REQ-029 Release reset, no inputs -> outSel 00 for 50 cycles, 01 for 50, 10 for 20, then 00; period 120 cycles.
REQ-030 inPed pulse of 1 cycle at green cycle 5 -> outPedPend = 1 next edge; yellow starts at green cycle 20; outPedPend clears on entry to red.
REQ-031 inPed pulse at green cycle 35 -> yellow starts immediately after the next ms tick (green cycle 40), not at cycle 50.
REQ-032 inMaint high during yellow on the cycle of its timeout -> outSel = 11 next edge; inMaint low -> outSel = 00 for a full 50 cycles.
REQ-033 rst pulse mid-green, coincident with inPed -> outSel = 00 and outPedPend = 0 asynchronously; the red phase then lasts 50 cycles.
REQ-034 inPed held high through red -> outPedPend = 0 only on the red-entry edge, re-set on the following edge.
